// File: rtl/uart_tx.sv
// UART transmitter: one word per valid/ready handshake, LSB first,
// optional parity and one or two stop bits.
`timescale 1ns / 1ps

module uart_tx #(
    parameter int CLK_RATE    = 100000000,
    parameter int BAUD_RATE   = 115200,
    parameter int WORD_LENGTH = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_tx_valid,
    input  logic [WORD_LENGTH-1:0] i_tx_byte,
    output logic                   o_tx_ready,
    output logic                   o_tx_serial,
    output logic                   o_tx_busy,
    output logic                   o_tx_done
);

    localparam int CLKS_PER_BIT = CLK_RATE / BAUD_RATE;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] DATA_LAST = 4'(WORD_LENGTH - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state, state_n;
    logic [BW-1:0]          baud, baud_n;
    logic [3:0]             bit_cnt, bit_cnt_n;
    logic [WORD_LENGTH-1:0] data, data_n;
    logic                   par, par_n;
    logic                   serial, serial_n;
    logic                   baud_end;
    logic                   last_stop;
    logic                   take;

    assign baud_end    = (baud == BAUD_LAST);
    assign last_stop   = (state == S_STOP) && baud_end && (bit_cnt == STOP_LAST);
    assign o_tx_ready  = (state == S_IDLE) || last_stop;
    assign take        = i_tx_valid && o_tx_ready;
    assign o_tx_busy   = (state != S_IDLE);
    assign o_tx_done   = last_stop;
    assign o_tx_serial = serial;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            data    <= '0;
            par     <= 1'b0;
            serial  <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_cnt_n;
            data    <= data_n;
            par     <= par_n;
            serial  <= serial_n;
        end
    end

    // serial_n is the level of the next line bit, so the line is a pure flop
    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_cnt_n = bit_cnt;
        data_n    = data;
        par_n     = par;
        serial_n  = serial;
        if (take) begin
            state_n   = S_START;
            baud_n    = '0;
            bit_cnt_n = '0;
            data_n    = i_tx_byte;
            par_n     = (^i_tx_byte) ^ (PARITY == 1);
            serial_n  = 1'b0;
        end else if (state != S_IDLE) begin
            if (!baud_end) begin
                baud_n = baud + 1'b1;
            end else begin
                baud_n = '0;
                unique case (state)
                    S_START: begin
                        state_n   = S_DATA;
                        bit_cnt_n = '0;
                        serial_n  = data[0];
                    end
                    S_DATA: begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt_n = '0;
                            if (PARITY != 0) begin
                                state_n  = S_PARITY;
                                serial_n = par;
                            end else begin
                                state_n  = S_STOP;
                                serial_n = 1'b1;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                            data_n    = data >> 1;
                            serial_n  = data[1];
                        end
                    end
                    S_PARITY: begin
                        state_n   = S_STOP;
                        bit_cnt_n = '0;
                        serial_n  = 1'b1;
                    end
                    S_STOP: begin
                        serial_n = 1'b1;
                        if (bit_cnt == STOP_LAST) begin
                            state_n = S_IDLE;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state_n  = S_IDLE;
                        serial_n = 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (default rate, fast 8N1, even parity,
// odd parity with two stop bits) checked by a line monitor and scoreboard.
`timescale 1ns / 1ps

module tb_uart_tx;

    typedef struct {
        logic [15:0] bits;
        int          n;
        bit          may_abort;
    } frame_t;

    typedef struct {
        int          k;
        logic [7:0]  d;
        logic [15:0] bits;
        int          n;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       v    [4];
    logic [7:0] b    [4];
    logic       rdy  [4];
    logic       ser  [4];
    logic       busy [4];
    logic       done [4];

    frame_t sbq [4][$];
    int     cpb [4] = '{868, 16, 16, 15};
    int     stray [4];
    bit     mon_act [4];
    int     errors = 0;
    int     checks = 0;
    vec_t   vecs [10];

    always #5 clk = ~clk;

    uart_tx u0 (
        .i_clk(clk), .i_rst(rst), .i_tx_valid(v[0]), .i_tx_byte(b[0]),
        .o_tx_ready(rdy[0]), .o_tx_serial(ser[0]),
        .o_tx_busy(busy[0]), .o_tx_done(done[0])
    );

    uart_tx #(.CLK_RATE(1600000), .BAUD_RATE(100000)) u1 (
        .i_clk(clk), .i_rst(rst), .i_tx_valid(v[1]), .i_tx_byte(b[1]),
        .o_tx_ready(rdy[1]), .o_tx_serial(ser[1]),
        .o_tx_busy(busy[1]), .o_tx_done(done[1])
    );

    uart_tx #(.CLK_RATE(1600000), .BAUD_RATE(100000), .PARITY(2)) u2 (
        .i_clk(clk), .i_rst(rst), .i_tx_valid(v[2]), .i_tx_byte(b[2]),
        .o_tx_ready(rdy[2]), .o_tx_serial(ser[2]),
        .o_tx_busy(busy[2]), .o_tx_done(done[2])
    );

    uart_tx #(.CLK_RATE(1500000), .BAUD_RATE(100000),
              .PARITY(1), .STOP_BITS(2)) u3 (
        .i_clk(clk), .i_rst(rst), .i_tx_valid(v[3]), .i_tx_byte(b[3]),
        .o_tx_ready(rdy[3]), .o_tx_serial(ser[3]),
        .o_tx_busy(busy[3]), .o_tx_done(done[3])
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Checks every cycle of each frame against the expected bit sequence
    task automatic mon(input int k);
        frame_t      e;
        logic [15:0] got;
        int          glitch;
        int          stat;
        bit          aborted;
        logic        last;
        forever begin
            @(negedge clk);
            if (rst || ser[k] !== 1'b0) begin
                if (done[k] === 1'b1) stray[k]++;
                continue;
            end
            if (sbq[k].size() == 0) begin
                chk($sformatf("unexpected_frame%0d", k), 1, 0);
                repeat (cpb[k] * 13) @(negedge clk);
                continue;
            end
            e = sbq[k].pop_front();
            mon_act[k] = 1'b1;
            got = '0;
            glitch = 0;
            stat = 0;
            aborted = 1'b0;
            for (int i = 0; i < e.n; i++) begin
                for (int c = 0; c < cpb[k]; c++) begin
                    if (i != 0 || c != 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    last = (i == e.n - 1) && (c == cpb[k] - 1);
                    if (c == cpb[k] / 2) got[i] = ser[k];
                    if (ser[k] !== e.bits[i]) glitch++;
                    if (rdy[k] !== last || done[k] !== last || busy[k] !== 1'b1)
                        stat++;
                end
                if (aborted) break;
            end
            mon_act[k] = 1'b0;
            if (aborted) begin
                if (!e.may_abort) chk($sformatf("abort%0d", k), 1, 0);
            end else begin
                chk($sformatf("frame%0d", k), got, e.bits);
                chk($sformatf("bit_hold%0d", k), glitch, 0);
                chk($sformatf("status%0d", k), stat, 0);
            end
        end
    endtask

    task automatic send(input int k, input logic [7:0] d,
                        input logic [15:0] bits, input int n,
                        input bit keep, input bit may_abort,
                        output longint tx);
        frame_t e;
        int     t;
        @(negedge clk);
        b[k] = d;
        v[k] = 1'b1;
        t = 0;
        while (rdy[k] !== 1'b1 && t < 40000) begin
            @(negedge clk);
            t++;
        end
        if (rdy[k] !== 1'b1) begin
            chk("send_timeout", 0, 1);
            v[k] = 1'b0;
            tx = 0;
            return;
        end
        e.bits = bits;
        e.n = n;
        e.may_abort = may_abort;
        sbq[k].push_back(e);
        @(posedge clk);
        tx = $time;
        #1;
        if (!keep) v[k] = 1'b0;
        b[k] = 8'($urandom);
    endtask

    task automatic wait_idle(input int k);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(sbq[k].size() == 0 && !mon_act[k] && busy[k] === 1'b0)
                   && t < 40000);
        if (t >= 40000) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        longint tx0, tx1, tx2;
        int     cnt;
        vecs[0] = '{1, 8'h37, 16'b1001101110, 10};
        vecs[1] = '{1, 8'h00, 16'b1000000000, 10};
        vecs[2] = '{1, 8'hFF, 16'b1111111110, 10};
        vecs[3] = '{1, 8'h55, 16'b1010101010, 10};
        vecs[4] = '{1, 8'hA5, 16'b1101001010, 10};
        vecs[5] = '{2, 8'h37, 16'b11001101110, 11};
        vecs[6] = '{2, 8'h01, 16'b11000000010, 11};
        vecs[7] = '{2, 8'h03, 16'b10000000110, 11};
        vecs[8] = '{3, 8'h37, 16'b110001101110, 12};
        vecs[9] = '{3, 8'h00, 16'b111000000000, 12};

        for (int k = 0; k < 4; k++) begin
            v[k] = 1'b0;
            b[k] = '0;
            stray[k] = 0;
            mon_act[k] = 1'b0;
        end
        rst = 1'b1;
        fork
            mon(0);
            mon(1);
            mon(2);
            mon(3);
        join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++)
            chk($sformatf("reset_state%0d", k),
                {ser[k], rdy[k], busy[k], done[k]}, 4'b1100);
        @(posedge clk);
        #1 rst = 1'b0;

        // Long idle: line stays high, no done
        cnt = 0;
        repeat (20000) begin
            @(negedge clk);
            if (ser[1] !== 1'b1 || done[1] !== 1'b0 || rdy[1] !== 1'b1) cnt++;
        end
        chk("idle_line", cnt, 0);

        // Default rate: done seen at the edge 10*868 cycles after transfer
        send(0, 8'h37, 16'b1001101110, 10, 1'b0, 1'b0, tx0);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (done[0] !== 1'b1 && cnt < 20000);
        chk("done_latency", cnt, 10 * 868);
        wait_idle(0);

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].k, vecs[i].d, vecs[i].bits, vecs[i].n,
                 1'b0, 1'b0, tx0);
            wait_idle(vecs[i].k);
        end

        // Valid held high: three frames with zero gap
        send(1, 8'h00, 16'b1000000000, 10, 1'b1, 1'b0, tx0);
        send(1, 8'hFF, 16'b1111111110, 10, 1'b1, 1'b0, tx1);
        send(1, 8'h55, 16'b1010101010, 10, 1'b0, 1'b0, tx2);
        chk("b2b_gap1", tx1 - tx0, 10 * 16 * 10);
        chk("b2b_gap2", tx2 - tx1, 10 * 16 * 10);
        wait_idle(1);

        // Reset during data bit 3 aborts the frame
        send(1, 8'h37, 16'b1001101110, 10, 1'b0, 1'b1, tx0);
        repeat (70) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_state", {ser[1], rdy[1], busy[1], done[1]}, 4'b1100);
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (done[1] !== 1'b0 || ser[1] !== 1'b1) cnt++;
        end
        chk("rst_no_done", cnt, 0);
        send(1, 8'h37, 16'b1001101110, 10, 1'b0, 1'b0, tx0);
        wait_idle(1);

        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stray_done%0d", k), stray[k], 0);
            chk($sformatf("sb_left%0d", k), sbq[k].size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
